// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, control constants and stall decoding for the EX/MEM register
package ex_mem_pkg;
  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int DoubleRegBus = 64;
  localparam int StallBus     = 6;
  localparam int STALL_EX     = 3;
  localparam int STALL_MEM    = 4;
  localparam logic RstEnable    = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } act_e;
  // EX stalled with MEM running inserts a bubble; both stalled holds; EX-running-MEM-stalled advances.
  function automatic act_e stall_act(input logic flush, input logic stall_ex, input logic stall_mem);
    return flush ? ACT_FLUSH :
           (stall_ex == Stop && stall_mem == NoStop) ? ACT_BUBBLE :
           (stall_ex == Stop) ? ACT_HOLD : ACT_ADVANCE;
  endfunction
endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with stall/flush and madd/msub partial carry (EX_MEM_BUBBLE_CNT_EN adds a bubble counter)
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_waddr_reg,
  input  logic                    ex_we_reg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic                    ex_whilo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [1:0]              cnt_i,
  output logic [RegAddrBus-1:0]   waddr_reg_o,
  output logic                    we_reg_o,
  output logic [RegBus-1:0]       wdata_o,
  output logic [RegBus-1:0]       hi_o,
  output logic [RegBus-1:0]       lo_o,
  output logic                    whilo_o,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [1:0]              cnt_o,
  output logic [RegBus-1:0]       bubble_cnt_o
);
  act_e act;
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};
  // Decode the stall/flush controls into one action for this edge
  always_comb act = stall_act(flush, stall[STALL_EX], stall[STALL_MEM]);
  // Write-back fields and the madd/msub partial; reset and flush both drop to NOP
  always_ff @(posedge clk) begin
    if (rst == RstEnable || act == ACT_FLUSH) begin
      waddr_reg_o <= NOPRegAddr;
      we_reg_o    <= WriteDisable;
      wdata_o     <= ZeroWord;
      hi_o        <= ZeroWord;
      lo_o        <= ZeroWord;
      whilo_o     <= WriteDisable;
      hilo_o      <= '0;
      cnt_o       <= '0;
    end else if (act == ACT_BUBBLE) begin
      waddr_reg_o <= NOPRegAddr;
      we_reg_o    <= WriteDisable;
      wdata_o     <= ZeroWord;
      hi_o        <= ZeroWord;
      lo_o        <= ZeroWord;
      whilo_o     <= WriteDisable;
      hilo_o      <= hilo_i;
      cnt_o       <= cnt_i;
    end else if (act == ACT_ADVANCE) begin
      waddr_reg_o <= ex_waddr_reg;
      we_reg_o    <= ex_we_reg;
      wdata_o     <= ex_wdata;
      hi_o        <= ex_hi;
      lo_o        <= ex_lo;
      whilo_o     <= ex_whilo;
      hilo_o      <= '0;
      cnt_o       <= '0;
    end
  end
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [RegBus-1:0] bubble_cnt_q;
  // Count edges that insert a bubble; only reset clears it, wraps naturally
  always_ff @(posedge clk) begin
    if (rst == RstEnable) bubble_cnt_q <= ZeroWord;
    else if (act == ACT_BUBBLE) bubble_cnt_q <= bubble_cnt_q + 1'b1;
  end
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign bubble_cnt_o = ZeroWord;
`endif
endmodule
